// File: rtl/proc_scheduler_pkg.sv
// Shared definitions for the round-robin process scheduler: default sizing,
// the reset quantum and the FSM state encoding.
package proc_scheduler_pkg;

    localparam int NPROC_DEF       = 8;    // process slots (power of two, 2..8)
    localparam int QW_DEF          = 16;   // quantum counter width
    localparam int DEF_QUANTUM_DEF = 100;  // quantum loaded at reset

    typedef enum logic [1:0] {
        S_IDLE,    // nothing scheduled
        S_RUN,     // cur_proc owns the core, quantum counting down
        S_REQ,     // preemption requested, waiting for swap_ack
        S_SWITCH   // single cycle: install next_proc, reload quantum
    } state_t;

endpackage

// File: rtl/proc_scheduler_if.sv
// Core <-> scheduler signal bundle. The master side is the core / OS
// (drives control and process management), the slave side is the scheduler.
interface proc_scheduler_if
    import proc_scheduler_pkg::*;
#(
    parameter int NPROC = NPROC_DEF,
    parameter int QW    = QW_DEF
);
    localparam int LW = $clog2(NPROC);

    logic             sched_en;
    logic             hlt;
    logic             kernel_mode;
    logic             quantum_wr;
    logic [QW-1:0]    quantum_in;
    logic             proc_create;
    logic             proc_kill;
    logic [LW-1:0]    proc_id;
    logic             swap_ack;
    logic             intrpt_req;
    logic [LW-1:0]    cur_proc;
    logic [LW-1:0]    next_proc;
    logic [NPROC-1:0] ready_mask;
    logic             idle;

    modport master (
        output sched_en, hlt, kernel_mode, quantum_wr, quantum_in,
               proc_create, proc_kill, proc_id, swap_ack,
        input  intrpt_req, cur_proc, next_proc, ready_mask, idle
    );

    modport slave (
        input  sched_en, hlt, kernel_mode, quantum_wr, quantum_in,
               proc_create, proc_kill, proc_id, swap_ack,
        output intrpt_req, cur_proc, next_proc, ready_mask, idle
    );

endinterface

// File: rtl/proc_scheduler_rr_picker.sv
// Round-robin search: first ready slot strictly after cur_proc, wrapping
// NPROC-1 -> 0. cur_proc itself is visited last, so it is returned only when
// it is the sole ready slot. Returns 0 with valid=0 when nothing is ready.
module proc_scheduler_rr_picker #(
    parameter int NPROC = 8,
    localparam int LW   = $clog2(NPROC)
) (
    input  logic [NPROC-1:0] ready_mask,
    input  logic [LW-1:0]    cur_proc,
    output logic [LW-1:0]    next_proc,
    output logic             valid
);

    logic [LW-1:0] idx;

    // Scan farthest-to-nearest so the nearest ready slot is the last writer.
    // NOTE: every always_comb output gets a default first; a path that skips an assignment would infer a latch.
    always_comb begin
        next_proc = '0;
        idx       = '0;
        valid     = |ready_mask;
        for (int i = NPROC; i >= 1; i--) begin
            idx = LW'((int'(cur_proc) + i) % NPROC);
            if (ready_mask[idx]) begin
                next_proc = idx;
            end
        end
    end

endmodule

// File: rtl/proc_scheduler.sv
// Quantum-based round-robin process scheduler. Counts down the running
// process's quantum, requests preemption from the interruption logic when
// it expires and another process is ready, and installs the successor once
// the core acknowledges the context swap.
module proc_scheduler
    import proc_scheduler_pkg::*;
#(
    parameter int NPROC       = NPROC_DEF,
    parameter int QW          = QW_DEF,
    parameter int DEF_QUANTUM = DEF_QUANTUM_DEF
) (
    input logic              clock,
    input logic              reset,
    proc_scheduler_if.slave  bus
);

    localparam int LW = $clog2(NPROC);

    state_t           state, state_nxt;
    logic [LW-1:0]    cur_proc, cur_proc_nxt;
    logic [LW-1:0]    next_q, next_q_nxt;     // successor frozen for REQ / chosen in IDLE
    logic [NPROC-1:0] ready_mask, mask_nxt;
    logic [QW-1:0]    count, count_nxt;
    logic [QW-1:0]    quantum;
    logic             intrpt_req;
    logic             idle;

    logic [LW-1:0]    pick_base;
    logic [LW-1:0]    pick;
    logic             pick_valid;
    logic             dec;
    logic             other_nxt;
    logic [NPROC-1:0] cur_onehot;

    // Ready bits after this cycle's create/kill; kill is applied last so it wins.
    always_comb begin
        mask_nxt = ready_mask;
        if (bus.proc_create) mask_nxt[bus.proc_id] = 1'b1;
        if (bus.proc_kill)   mask_nxt[bus.proc_id] = 1'b0;
    end

    // Search origin: IDLE wants the lowest ready slot (start after NPROC-1);
    // SWITCH re-validates the frozen choice (first ready at or after next_q);
    // otherwise search after the running process.
    always_comb begin
        pick_base = cur_proc;
        if (state == S_IDLE)   pick_base = LW'(NPROC - 1);
        if (state == S_SWITCH) pick_base = next_q - LW'(1);
    end

    proc_scheduler_rr_picker #(.NPROC(NPROC)) rr_picker (
        .ready_mask (ready_mask),
        .cur_proc   (pick_base),
        .next_proc  (pick),
        .valid      (pick_valid)
    );

    // Next-state, quantum countdown and process selection.
    always_comb begin
        state_nxt    = state;
        cur_proc_nxt = cur_proc;
        next_q_nxt   = next_q;
        count_nxt    = count;
        dec          = bus.sched_en && !bus.hlt && !bus.kernel_mode;
        cur_onehot   = '0;
        cur_onehot[cur_proc] = 1'b1;
        other_nxt    = |(mask_nxt & ~cur_onehot);

        case (state)
            S_IDLE: begin
                if (bus.sched_en && pick_valid) begin
                    state_nxt  = S_SWITCH;
                    next_q_nxt = pick;
                end
            end
            S_RUN: begin
                if (mask_nxt == '0) begin
                    state_nxt = S_IDLE;               // cur_proc keeps its last value
                end else if (!mask_nxt[cur_proc]) begin
                    // Running process was killed: it cannot keep the core, so
                    // the switch is requested regardless of sched_en.
                    state_nxt  = S_REQ;
                    next_q_nxt = pick;
                    count_nxt  = '0;
                end else if (dec) begin
                    if (count == QW'(1)) begin
                        if (other_nxt) begin
                            state_nxt  = S_REQ;
                            next_q_nxt = pick;
                            count_nxt  = '0;
                        end else begin
                            count_nxt = quantum;      // sole ready process keeps running
                        end
                    end else begin
                        count_nxt = count - QW'(1);
                    end
                end
            end
            S_REQ: begin
                // sched_en is ignored here: an issued request runs to completion.
                if (bus.swap_ack) state_nxt = S_SWITCH;
            end
            S_SWITCH: begin
                if (!pick_valid) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt    = S_RUN;
                    cur_proc_nxt = pick;
                    count_nxt    = quantum;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register; intrpt_req and idle are registered from the next state.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cur_proc   <= '0;
            next_q     <= '0;
            ready_mask <= '0;
            count      <= '0;
            quantum    <= QW'(DEF_QUANTUM);
            intrpt_req <= 1'b0;
            idle       <= 1'b1;
        end else begin
            state      <= state_nxt;
            cur_proc   <= cur_proc_nxt;
            next_q     <= next_q_nxt;
            ready_mask <= mask_nxt;
            count      <= count_nxt;
            if (bus.quantum_wr && (bus.quantum_in != '0)) begin
                quantum <= bus.quantum_in;            // used from the next reload on
            end
            intrpt_req <= (state_nxt == S_REQ);
            idle       <= (state_nxt == S_IDLE);
        end
    end

    assign bus.intrpt_req = intrpt_req;
    assign bus.cur_proc   = cur_proc;
    assign bus.next_proc  = (state == S_REQ) ? next_q : pick;
    assign bus.ready_mask = ready_mask;
    assign bus.idle       = idle;

endmodule

// File: tb/tb_proc_scheduler.sv
// Directed bench for proc_scheduler: a vector table for ready-mask
// management in IDLE, then hand-written sequences for quantum expiry,
// wrap-around, freeze, kill handling and asynchronous reset.
module tb_proc_scheduler;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;

    proc_scheduler_if #(.NPROC(8), .QW(16)) bus ();

    proc_scheduler #(.NPROC(8), .QW(16), .DEF_QUANTUM(100)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       create;
        logic       kill;
        logic [2:0] id;
        logic [7:0] exp_mask;
        logic [2:0] exp_next;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        bus.sched_en    = 1'b0;
        bus.hlt         = 1'b0;
        bus.kernel_mode = 1'b0;
        bus.quantum_wr  = 1'b0;
        bus.quantum_in  = '0;
        bus.proc_create = 1'b0;
        bus.proc_kill   = 1'b0;
        bus.proc_id     = '0;
        bus.swap_ack    = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic create(input logic [2:0] id);
        bus.proc_create = 1'b1;
        bus.proc_id     = id;
        tick();
        bus.proc_create = 1'b0;
    endtask

    task automatic kill(input logic [2:0] id);
        bus.proc_kill = 1'b1;
        bus.proc_id   = id;
        tick();
        bus.proc_kill = 1'b0;
    endtask

    task automatic set_quantum(input logic [15:0] q);
        bus.quantum_wr = 1'b1;
        bus.quantum_in = q;
        tick();
        bus.quantum_wr = 1'b0;
    endtask

    task automatic ack();
        bus.swap_ack = 1'b1;
        tick();
        bus.swap_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_cnt;
        int q;

        vecs[0]  = '{1'b1, 1'b0, 3'd3, 8'h08, 3'd3};
        vecs[1]  = '{1'b1, 1'b0, 3'd6, 8'h48, 3'd3};
        vecs[2]  = '{1'b1, 1'b0, 3'd1, 8'h4A, 3'd1};
        vecs[3]  = '{1'b0, 1'b1, 3'd1, 8'h48, 3'd3};
        vecs[4]  = '{1'b1, 1'b1, 3'd5, 8'h48, 3'd3};  // create+kill: kill wins
        vecs[5]  = '{1'b0, 1'b1, 3'd3, 8'h40, 3'd6};
        vecs[6]  = '{1'b0, 1'b1, 3'd6, 8'h00, 3'd0};
        vecs[7]  = '{1'b1, 1'b0, 3'd7, 8'h80, 3'd7};
        vecs[8]  = '{1'b1, 1'b0, 3'd0, 8'h81, 3'd0};
        vecs[9]  = '{1'b0, 1'b1, 3'd7, 8'h01, 3'd0};
        vecs[10] = '{1'b0, 1'b1, 3'd0, 8'h00, 3'd0};

        // ---- reset state ----
        do_reset();
        check("rst_intrpt", 32'(bus.intrpt_req), 0);
        check("rst_cur",    32'(bus.cur_proc),   0);
        check("rst_next",   32'(bus.next_proc),  0);
        check("rst_mask",   32'(bus.ready_mask), 0);
        check("rst_idle",   32'(bus.idle),       1);
        check("rst_count",  32'(dut.count),      0);
        check("rst_quant",  32'(dut.quantum),    100);

        // ---- ready-mask table, IDLE with sched_en low ----
        for (int i = 0; i < 11; i++) begin
            bus.proc_create = vecs[i].create;
            bus.proc_kill   = vecs[i].kill;
            bus.proc_id     = vecs[i].id;
            tick();
            bus.proc_create = 1'b0;
            bus.proc_kill   = 1'b0;
            check($sformatf("tbl%0d_mask", i), 32'(bus.ready_mask), 32'(vecs[i].exp_mask));
            check($sformatf("tbl%0d_next", i), 32'(bus.next_proc),  32'(vecs[i].exp_next));
            check($sformatf("tbl%0d_idle", i), 32'(bus.idle),       1);
        end

        // ---- basic preemption: ready {0,3}, quantum 4 ----
        do_reset();
        set_quantum(16'd0);
        check("qzero_ignored", 32'(dut.quantum), 100);
        set_quantum(16'd4);
        check("q_written", 32'(dut.quantum), 4);
        create(3'd0);
        create(3'd3);
        bus.sched_en = 1'b1;
        tick();                                   // IDLE -> SWITCH
        check("a_idle_low",  32'(bus.idle),      0);
        check("a_lowest",    32'(bus.next_proc), 0);
        tick();                                   // SWITCH -> RUN
        check("a_cur0",      32'(bus.cur_proc),  0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("a_run%0d_intrpt", i), 32'(bus.intrpt_req), (i == 4) ? 1 : 0);
        end
        check("a_next3", 32'(bus.next_proc), 3);
        bus.sched_en = 1'b0;                      // must not abort the request
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("a_hold%0d", i), 32'(bus.intrpt_req), 1);
        end
        bus.sched_en = 1'b1;
        ack();                                    // REQ -> SWITCH
        check("a_intrpt_drop", 32'(bus.intrpt_req), 0);
        check("a_cur_still0",  32'(bus.cur_proc),   0);
        tick();
        check("a_cur3",        32'(bus.cur_proc),   3);

        // ---- sole ready process: reload, never request; quantum change at reload ----
        do_reset();
        set_quantum(16'd3);
        create(3'd5);
        bus.sched_en = 1'b1;
        tick();
        tick();
        check("b_cur5",  32'(bus.cur_proc), 5);
        q = 3;
        exp_cnt = 3;
        check("b_cnt0",  32'(dut.count), 32'(exp_cnt));
        for (int i = 0; i < 12; i++) begin
            bus.quantum_wr = (i == 4);
            bus.quantum_in = 16'd2;
            tick();
            exp_cnt = (exp_cnt == 1) ? q : exp_cnt - 1;
            if (i == 4) q = 2;
            check($sformatf("b_cnt%0d", i + 1), 32'(dut.count), 32'(exp_cnt));
            check($sformatf("b_noreq%0d", i + 1), 32'(bus.intrpt_req), 0);
        end
        bus.quantum_wr = 1'b0;

        // ---- wrap-around: ready {2,6} ----
        do_reset();
        set_quantum(16'd2);
        create(3'd2);
        create(3'd6);
        bus.sched_en = 1'b1;
        tick();
        tick();
        check("c_cur2", 32'(bus.cur_proc), 2);
        tick();
        tick();
        check("c_req1", 32'(bus.intrpt_req), 1);
        check("c_next6", 32'(bus.next_proc), 6);
        ack();
        tick();
        check("c_cur6", 32'(bus.cur_proc), 6);
        tick();
        tick();
        check("c_req2", 32'(bus.intrpt_req), 1);
        check("c_wrap", 32'(bus.next_proc), 2);
        ack();
        tick();
        check("c_cur2b", 32'(bus.cur_proc), 2);

        // ---- freeze: 5 cycles hlt + 5 cycles kernel_mode mid-quantum ----
        do_reset();
        set_quantum(16'd5);
        create(3'd0);
        create(3'd1);
        bus.sched_en = 1'b1;
        tick();
        tick();
        check("d_cur0", 32'(bus.cur_proc), 0);
        tick();
        tick();
        bus.hlt = 1'b1;
        repeat (5) tick();
        bus.hlt = 1'b0;
        bus.kernel_mode = 1'b1;
        repeat (5) tick();
        bus.kernel_mode = 1'b0;
        check("d_frozen_cnt", 32'(dut.count), 3);
        check("d_frozen_req", 32'(bus.intrpt_req), 0);
        tick();
        tick();
        check("d_early", 32'(bus.intrpt_req), 0);
        tick();
        check("d_expiry", 32'(bus.intrpt_req), 1);

        // ---- kill running process, then kill last ready ----
        do_reset();
        create(3'd1);
        create(3'd4);
        bus.sched_en = 1'b1;
        tick();
        tick();
        check("e_cur1", 32'(bus.cur_proc), 1);
        tick();
        tick();
        kill(3'd1);
        check("e_req",  32'(bus.intrpt_req), 1);
        check("e_next", 32'(bus.next_proc),  4);
        check("e_mask", 32'(bus.ready_mask), 32'h10);
        ack();
        tick();
        check("e_cur4", 32'(bus.cur_proc), 4);
        kill(3'd4);
        check("e_idle",     32'(bus.idle),       1);
        check("e_cur_hold", 32'(bus.cur_proc),   4);
        check("e_mask0",    32'(bus.ready_mask), 0);

        // ---- kill of next_proc during REQ ----
        do_reset();
        set_quantum(16'd2);
        create(3'd0);
        create(3'd3);
        create(3'd5);
        bus.sched_en = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("f_req",  32'(bus.intrpt_req), 1);
        check("f_next", 32'(bus.next_proc),  3);
        kill(3'd3);
        check("f_req_kept",  32'(bus.intrpt_req), 1);
        check("f_next_frzn", 32'(bus.next_proc),  3);
        ack();
        check("f_reeval", 32'(bus.next_proc), 5);
        tick();
        check("f_cur5", 32'(bus.cur_proc), 5);
        tick();
        tick();
        check("f_req2",  32'(bus.intrpt_req), 1);
        check("f_next0", 32'(bus.next_proc),  0);
        kill(3'd0);
        kill(3'd5);
        check("f_req_empty", 32'(bus.intrpt_req), 1);
        ack();
        tick();
        check("f_idle",     32'(bus.idle),     1);
        check("f_cur_hold", 32'(bus.cur_proc), 5);

        // ---- asynchronous reset while requesting ----
        do_reset();
        set_quantum(16'd2);
        create(3'd1);
        create(3'd2);
        bus.sched_en = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("g_req", 32'(bus.intrpt_req), 1);
        #2;
        reset = 1'b1;
        #1;
        check("g_intrpt", 32'(bus.intrpt_req), 0);
        check("g_mask",   32'(bus.ready_mask), 0);
        check("g_quant",  32'(dut.quantum),    100);
        check("g_idle",   32'(bus.idle),       1);
        check("g_cur",    32'(bus.cur_proc),   0);
        tick();
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
